// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller sequencing IF/ID/EXE/MEM/WB and driving datapath controls.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       ext_op,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic is_r, addu, subu, jr, ori, lw, sw, beq, lui, j, jal, alu_path;
  logic [2:0] alu_op_dec;
  always_comb begin
    is_r = opcode == 6'b000000;
    addu = is_r && funct == 6'b100001;
    subu = is_r && funct == 6'b100011;
    jr   = is_r && funct == 6'b001000;
    ori  = opcode == 6'b001101;
    lw   = opcode == 6'b100011;
    sw   = opcode == 6'b101011;
    beq  = opcode == 6'b000100;
    lui  = opcode == 6'b001111;
    j    = opcode == 6'b000010;
    jal  = opcode == 6'b000011;
    alu_path = addu | subu | ori | lui | lw | sw | beq;
    alu_op_dec = (subu | beq) ? 3'b001 : ori ? 3'b010 : lui ? 3'b011 : 3'b000;
  end
  always_comb begin
    state_d    = S_IF;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    ext_op     = (lw | sw | beq) ? 2'b01 : lui ? 2'b10 : 2'b00;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    dm_we      = 1'b0;
    instr_done = 1'b0;
    // ALU controls stay asserted from EXE through MEM/WB so the result is stable at write time
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      alu_op  = alu_op_dec;
      alu_src = ori | lui | lw | sw;
    end
    case (state_q)
      S_IF: begin
        pc_we   = 1'b1;
        ir_we   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (j | jal | jr) begin
          pc_we      = 1'b1;
          pc_src     = jr ? 2'b11 : 2'b10;
          reg_we     = jal;
          reg_dst    = jal ? 2'b10 : 2'b00;
          wd_sel     = jal ? 2'b10 : 2'b00;
          instr_done = 1'b1;
        end else if (alu_path) state_d = S_EXE;
        else instr_done = 1'b1;
      end
      S_EXE: begin
        if (beq) begin
          pc_src     = 2'b01;
          pc_we      = zero;
          instr_done = 1'b1;
        end else state_d = (lw | sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dm_we      = sw;
        instr_done = sw;
        state_d    = sw ? S_IF : S_WB;
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = is_r ? 2'b01 : 2'b00;
        wd_sel     = lw ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      default: ext_op = 2'b00;
    endcase
    if (reset) begin
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 2'b00;
      wd_sel     = 2'b00;
      ext_op     = 2'b00;
      alu_src    = 1'b0;
      alu_op     = 3'b000;
      dm_we      = 1'b0;
      instr_done = 1'b0;
    end
    retired_d = retired_q + CNT_W'(instr_done);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  assign state   = state_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven per-cycle check of mc_ctrl state, controls and retire count.
module tb_mc_ctrl;
  logic clk = 1'b0, reset;
  logic [5:0] opcode, funct;
  logic zero;
  logic pc_we, ir_we, reg_we, alu_src, dm_we, instr_done;
  logic [1:0] pc_src, reg_dst, wd_sel, ext_op;
  logic [2:0] alu_op, state;
  logic [31:0] retired;
  logic [16:0] act;
  int n_chk = 0, n_fail = 0, ret_cnt = 0;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .ext_op(ext_op), .alu_src(alu_src), .alu_op(alu_op), .dm_we(dm_we),
    .state(state), .instr_done(instr_done), .retired(retired)
  );

  always #5 clk = ~clk;
  assign act = {pc_we, pc_src, ir_we, reg_we, reg_dst, wd_sel, ext_op, alu_src, alu_op, dm_we, instr_done};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [2:0]  st;
    logic [16:0] ctrl;
    logic [31:0] ret;
  } vec_t;
  vec_t vecs[$];

  localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_LUI = 6'b001111, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_JR = 6'b001000;

  function automatic logic [16:0] mk(input logic pw, input logic [1:0] ps, input logic iw, input logic rw,
                                     input logic [1:0] rd, input logic [1:0] ws, input logic [1:0] eo,
                                     input logic as, input logic [2:0] ao, input logic dw, input logic dn);
    return {pw, ps, iw, rw, rd, ws, eo, as, ao, dw, dn};
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic [2:0] st,
                     input logic [16:0] c);
    vecs.push_back('{op, fn, z, st, c, ret_cnt});
    if (c[0]) ret_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  initial begin
    // ori: IF, ID, EXE, WB
    add(OP_ORI, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_ORI, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_ORI, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
    add(OP_ORI, 0, 0, 4, mk(0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 1));
    // lw: five cycles
    add(OP_LW, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_LW, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_LW, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    add(OP_LW, 0, 0, 3, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    add(OP_LW, 0, 0, 4, mk(0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1));
    // sw: dm_we only in MEM
    add(OP_SW, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_SW, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_SW, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    add(OP_SW, 0, 0, 3, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1));
    // beq taken then not taken
    add(OP_BEQ, 0, 1, 0, mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_BEQ, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_BEQ, 0, 1, 2, mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    add(OP_BEQ, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_BEQ, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add(OP_BEQ, 0, 0, 2, mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    // jal, j, jr
    add(OP_JAL, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_JAL, 0, 0, 1, mk(1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 1));
    add(OP_J, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_J, 0, 0, 1, mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(OP_R, F_JR, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_R, F_JR, 0, 1, mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // addu, subu
    add(OP_R, F_ADDU, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_R, F_ADDU, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_R, F_ADDU, 0, 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_R, F_ADDU, 0, 4, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    add(OP_R, F_SUBU, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_R, F_SUBU, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_R, F_SUBU, 0, 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(OP_R, F_SUBU, 0, 4, mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1));
    // lui
    add(OP_LUI, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0));
    add(OP_LUI, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0));
    add(OP_LUI, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 2, 1, 3, 0, 0));
    add(OP_LUI, 0, 0, 4, mk(0, 0, 0, 1, 0, 0, 2, 1, 3, 0, 1));
    // unknown opcode and unknown R funct retire as nops
    add(6'b111111, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(6'b111111, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(OP_R, 6'b000000, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_R, 6'b000000, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add(OP_ORI, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    reset = 1'b1; opcode = OP_JAL; funct = 0; zero = 1'b1;
    @(negedge clk);
    chk("reset_ctrl", 32'(act), 0);
    chk("reset_state", 32'(state), 0);
    chk("reset_retired", retired, 0);
    @(posedge clk); #1 reset = 1'b0;
    foreach (vecs[i]) begin
      opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z;
      @(negedge clk);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_ctrl", i), 32'(act), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_retired", i), retired, vecs[i].ret);
      @(posedge clk); #1;
    end

    // reset in MEM of sw: no DM write, back to IF
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    opcode = OP_SW; funct = 0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("sw_reach_mem", 32'(state), 3);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mem_dm_we", 32'(dm_we), 0);
    chk("rst_mem_ctrl", 32'(act), 0);
    @(posedge clk); #1;
    chk("rst_mem_state", 32'(state), 0);
    chk("rst_mem_retired", retired, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fetch", 32'({pc_we, ir_we}), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS controller: sequences the shared datapath (PC, IR, GRF, ALU, EXT, DM) through IF/ID/EXE/MEM/WB states.
- Decodes opcode/funct from the IR and drives every datapath enable and mux select, including the EXT ext_op.
- Keeps a retired-instruction counter for bench checking.
- Supported: addu, subu, jr, ori, lw, sw, beq, lui, j, jal; any other encoding retires as a nop.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
opcode  input  6  IR[31:26], stable from the cycle after IF
funct  input  6  IR[5:0]
zero  input  1  ALU result == 0
pc_we  output  1  PC write enable
pc_src  output  2  00 PC+4, 01 branch target, 10 jump target, 11 GRF[rs]
ir_we  output  1  IR write enable
reg_we  output  1  GRF write enable
reg_dst  output  2  00 rt, 01 rd, 10 $31
wd_sel  output  2  00 ALU result, 01 DM data, 10 PC (already PC+4)
ext_op  output  2  00 zero-ext, 01 sign-ext, 10 imm<<16
alu_src  output  1  0 GRF[rt], 1 EXT output
alu_op  output  3  000 ADD, 001 SUB, 010 OR, 011 pass B
dm_we  output  1  DM write enable
state  output  3  current state, for debug
instr_done  output  1  high in the final cycle of each instruction
retired  output  CNT_W  count of completed instructions

Behaviour:
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4. `state` and `retired` are registered; all other outputs are combinational from state, opcode, funct and zero.
- Reset: state <= IF and retired <= 0. While reset is high, pc_we, ir_we, reg_we, dm_we and instr_done are forced to 0 and all selects read 0. Reset mid-instruction abandons it with no further writes.
- Default in every state: all enables 0, selects 0.
- ext_op depends on opcode only and is valid in all states:
  - ori -> 00
  - lw, sw, beq -> 01
  - lui -> 10
  - all others -> 00
- Opcodes: R=000000 (addu funct 100001, subu 100011, jr 001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
- IF: pc_we=1, pc_src=00, ir_we=1 -> ID.
- ID:
  - j: pc_we=1, pc_src=10, instr_done -> IF.
  - jal: same as j, plus reg_we=1, reg_dst=10, wd_sel=10.
  - jr: pc_we=1, pc_src=11, instr_done -> IF.
  - Unknown opcode, or R-type with unknown funct: instr_done -> IF (nop).
  - Otherwise -> EXE.
- EXE:
  - addu: alu_op=000, alu_src=0 -> WB.
  - subu: alu_op=001, alu_src=0 -> WB.
  - ori: alu_op=010, alu_src=1 -> WB.
  - lui: alu_op=011, alu_src=1 -> WB.
  - lw/sw: alu_op=000, alu_src=1 -> MEM.
  - beq: alu_op=001, alu_src=0, pc_src=01, pc_we=zero, instr_done -> IF.
- MEM:
  - ALU controls are held from EXE.
  - sw: dm_we=1, instr_done -> IF.
  - lw -> WB.
- WB: reg_we=1; ALU controls are held.
  - R-type: reg_dst=01, wd_sel=00.
  - ori/lui: reg_dst=00, wd_sel=00.
  - lw: reg_dst=00, wd_sel=01.
  - instr_done -> IF.
- retired increments on every clock edge where instr_done=1; it wraps modulo 2^CNT_W.
- Latency in cycles: j/jal/jr/nop 2, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.
- Illegal state codes 5..7 -> IF next cycle, with no writes.

Test Plan:
- Reset for 2 cycles, then release -> state=0, retired=0, all enables 0 during reset; first cycle after release pc_we=1, ir_we=1.
- opcode=001101 (ori) -> state sequence 0,1,2,4,0; in EXE ext_op=00, alu_op=010, alu_src=1; in WB reg_we=1, reg_dst=00; retired=1.
- lw (100011) then sw (101011) -> lw takes 5 cycles with wd_sel=01 and ext_op=01 in WB; sw has dm_we=1 only in MEM; retired=2 after 9 cycles.
- beq (000100) with zero=1, then again with zero=0 -> pc_we=1/pc_src=01 in EXE for the first, pc_we=0 for the second; each takes 3 cycles.
- jal (000011) -> in ID pc_we=1, pc_src=10, reg_we=1, reg_dst=10, wd_sel=10; 2 cycles; lui (001111) -> ext_op=10, alu_op=011.
- Opcode 111111 -> nop in 2 cycles, retired increments, no writes; reset asserted during MEM of sw -> dm_we=0, and state=0 next cycle.
